// File: rtl/stack_pkg.sv
// ---------------------------------------------------------------------------
// stack_pkg
//   Shared definitions for the hardware stack controller.
//   - stack_op_e    : request opcodes carried on req_op
//   - stack_state_e : sequencer states used by stack_ctrl
//   - is_read_op()  : true for the opcodes that produce a response word
// ---------------------------------------------------------------------------
package stack_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_TOP  = 2'b11
    } stack_op_e;

    typedef enum logic [1:0] {
        ST_SCRUB = 2'b00,
        ST_IDLE  = 2'b01,
        ST_RD    = 2'b10,
        ST_RSP   = 2'b11
    } stack_state_e;

    // POP and TOP both read the top-of-stack word and return it to the consumer.
    function automatic logic is_read_op(input stack_op_e op);
        return (op == OP_POP) || (op == OP_TOP);
    endfunction

endpackage

// File: rtl/stack_ptr_unit.sv
// ---------------------------------------------------------------------------
// stack_ptr_unit
//   Stack pointer register. SP points at the next free slot, so SP equals the
//   current depth: 0 is empty, NWORDS is full. It never wraps; the caller
//   only raises inc_i when not full and dec_i when not empty.
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset (SP -> 0)
//   inc_i    in   increment SP this cycle
//   dec_i    in   decrement SP this cycle
//   sp_o     out  current SP (AW+1 bits)
//   full_o   out  SP == NWORDS
//   empty_o  out  SP == 0
// ---------------------------------------------------------------------------
module stack_ptr_unit #(
    parameter int NWORDS = 1024,
    parameter int AW     = $clog2(NWORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [AW:0]   sp_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam logic [AW:0] FULL_VAL = (AW+1)'(NWORDS);
    localparam logic [AW:0] SP_ONE   = (AW+1)'(1);

    logic [AW:0] sp_q;
    logic [AW:0] sp_d;

    // Next SP: push adds one, pop removes one, otherwise hold.
    always_comb begin
        sp_d = sp_q;
        if (inc_i) begin
            sp_d = sp_q + SP_ONE;
        end else if (dec_i) begin
            sp_d = sp_q - SP_ONE;
        end
    end

    // SP register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    assign sp_o    = sp_q;
    assign full_o  = (sp_q == FULL_VAL);
    assign empty_o = (sp_q == '0);

endmodule

// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl
//   Sequencer for a single-port stack RAM (async read, write on clk). Accepts
//   PUSH/POP/TOP requests over valid/ready, drives the RAM write/address/data
//   lines, returns popped/top words over a valid/ready response channel and
//   keeps sticky overflow/underflow flags.
//
//   Optional feature macro: STACK_CTRL_SCRUB_EN
//     When defined, reset enters SCRUB and zeroes every RAM word, one per
//     cycle, before the first request is accepted (busy=1 meanwhile).
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_op, req_data        opcode (NOP/PUSH/POP/TOP) and PUSH data
//   rsp_valid/rsp_ready     response handshake
//   rsp_data                popped/top word
//   mem_we, mem_a, mem_din  to the RAM
//   mem_dout                from the RAM (combinational read)
//   count                   current depth (SP)
//   err_ovf, err_unf        sticky PUSH-while-full / POP-TOP-while-empty
//   clr_err                 clears both sticky flags
//   busy                    scrub in progress
// ---------------------------------------------------------------------------
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NWORDS = 1024,
    parameter int AW     = $clog2(NWORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             mem_we,
    output logic [AW-1:0]    mem_a,
    output logic [WIDTH-1:0] mem_din,
    input  logic [WIDTH-1:0] mem_dout,
    output logic [AW:0]      count,
    output logic             err_ovf,
    output logic             err_unf,
    input  logic             clr_err,
    output logic             busy
);

`ifdef STACK_CTRL_SCRUB_EN
    localparam stack_state_e RESET_STATE = ST_SCRUB;
    localparam logic [AW-1:0] LAST_ADDR  = AW'(NWORDS - 1);
`else
    localparam stack_state_e RESET_STATE = ST_IDLE;
`endif

    stack_state_e     state_q, state_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_unf_q, err_unf_d;

    logic             sp_inc, sp_dec;
    logic [AW:0]      sp;
    logic             full, empty;
    logic [AW-1:0]    sp_addr;
    logic             req_fire;
    stack_op_e        op;
    logic             ovf_set, unf_set;
    logic             we_raw;
    logic [AW-1:0]    a_mux;
    logic [WIDTH-1:0] din_mux;

`ifdef STACK_CTRL_SCRUB_EN
    logic [AW-1:0]    scrub_q;
`endif

    stack_ptr_unit #(
        .NWORDS (NWORDS),
        .AW     (AW)
    ) u_ptr (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (sp_inc),
        .dec_i   (sp_dec),
        .sp_o    (sp),
        .full_o  (full),
        .empty_o (empty)
    );

    assign op        = stack_op_e'(req_op);
    assign req_ready = (state_q == ST_IDLE);
    assign req_fire  = req_valid & req_ready;
    // A full stack has SP == NWORDS, which is not a valid RAM address.
    assign sp_addr   = full ? '0 : sp[AW-1:0];

    // Next-state, pointer control and RAM muxing. Errors on illegal
    // PUSH/POP/TOP are accepted requests that change nothing but a flag.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        sp_inc      = 1'b0;
        sp_dec      = 1'b0;
        ovf_set     = 1'b0;
        unf_set     = 1'b0;
        we_raw      = 1'b0;
        a_mux       = sp_addr;
        din_mux     = req_data;

        case (state_q)
            ST_SCRUB: begin
`ifdef STACK_CTRL_SCRUB_EN
                we_raw  = 1'b1;
                a_mux   = scrub_q;
                din_mux = '0;
                if (scrub_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_IDLE: begin
                if (req_fire) begin
                    if (op == OP_PUSH) begin
                        if (full) begin
                            ovf_set = 1'b1;
                        end else begin
                            we_raw = 1'b1;
                            sp_inc = 1'b1;
                        end
                    end else if (is_read_op(op)) begin
                        if (empty) begin
                            unf_set = 1'b1;
                        end else begin
                            // Low-bit wrap gives NWORDS-1 when SP == NWORDS.
                            rd_addr_d = sp[AW-1:0] - AW'(1);
                            sp_dec    = (op == OP_POP);
                            state_d   = ST_RD;
                        end
                    end
                end
            end
            ST_RD: begin
                a_mux       = rd_addr_q;
                rsp_data_d  = mem_dout;
                rsp_valid_d = 1'b1;
                state_d     = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new error outranks a clear arriving in the same cycle.
        err_ovf_d = ovf_set | (err_ovf_q & ~clr_err);
        err_unf_d = unf_set | (err_unf_q & ~clr_err);
    end

    // State, response and sticky-flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            rd_addr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_ovf_q   <= err_ovf_d;
            err_unf_q   <= err_unf_d;
        end
    end

`ifdef STACK_CTRL_SCRUB_EN
    // Scrub address counter; restarts at 0 on every reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            scrub_q <= '0;
        end else if (state_q == ST_SCRUB) begin
            scrub_q <= scrub_q + AW'(1);
        end
    end

    assign busy = (state_q == ST_SCRUB);
`else
    assign busy = 1'b0;
`endif

    // No RAM write may escape while reset is held.
    assign mem_we    = we_raw & ~reset;
    assign mem_a     = a_mux;
    assign mem_din   = din_mux;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign err_ovf   = err_ovf_q;
    assign err_unf   = err_unf_q;
    assign count     = sp;

endmodule

// File: tb/tb_stack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stack_ctrl
//   Directed bench for stack_ctrl with WIDTH=16, NWORDS=4 and a small
//   behavioural RAM. Inputs change on the falling edge; outputs are sampled
//   1 time unit after the falling edge.
// ---------------------------------------------------------------------------
module tb_stack_ctrl;
    import stack_pkg::*;

    localparam int WIDTH  = 16;
    localparam int NWORDS = 4;
    localparam int AW     = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = 2'b00;
    logic [WIDTH-1:0] req_data = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_data;
    logic             mem_we;
    logic [AW-1:0]    mem_a;
    logic [WIDTH-1:0] mem_din;
    logic [WIDTH-1:0] mem_dout;
    logic [AW:0]      count;
    logic             err_ovf;
    logic             err_unf;
    logic             clr_err = 1'b0;
    logic             busy;

    int nChecks = 0;
    int nFails  = 0;

    logic [WIDTH-1:0] ram [NWORDS];

    always #5 clk = ~clk;

    // Behavioural stack RAM: write on clock, combinational read.
    always @(posedge clk) begin
        if (mem_we) ram[mem_a] <= mem_din;
    end
    assign mem_dout = ram[mem_a];

    stack_ctrl #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mem_we(mem_we), .mem_a(mem_a), .mem_din(mem_din), .mem_dout(mem_dout),
        .count(count), .err_ovf(err_ovf), .err_unf(err_unf), .clr_err(clr_err), .busy(busy)
    );

    // Drive one cycle of request inputs at the falling edge, then settle.
    task automatic applyStimulus(input logic v, input logic [1:0] op,
                                 input logic [WIDTH-1:0] d, input logic clr);
        @(negedge clk);
        req_valid = v;
        req_op    = op;
        req_data  = d;
        clr_err   = clr;
        #1;
    endtask

    // After reset the controller is idle (or scrubbing first), empty and error-free.
    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(1'b0, OP_NOP, '0, 1'b0);
        nChecks++; if (mem_we !== 1'b0) begin nFails++; $display("[TB] FAIL reset_we: got %b exp 0", mem_we); end
        applyStimulus(1'b0, OP_NOP, '0, 1'b0);
        reset = 1'b0;
        #1;
`ifdef STACK_CTRL_SCRUB_EN
        for (int i = 0; i < NWORDS; i++) begin
            nChecks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin nFails++; $display("[TB] FAIL scrub_busy%0d: busy=%b ready=%b exp 1/0", i, busy, req_ready); end
            nChecks++; if (mem_we !== 1'b1 || mem_a !== AW'(i) || mem_din !== 16'h0) begin nFails++; $display("[TB] FAIL scrub_wr%0d: we=%b a=%0d din=%h exp 1/%0d/0000", i, mem_we, mem_a, mem_din, i); end
            applyStimulus(1'b0, OP_NOP, '0, 1'b0);
        end
`endif
        nChecks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ready: ready=%b busy=%b exp 1/0", req_ready, busy); end
        nChecks++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0) begin nFails++; $display("[TB] FAIL reset_rsp: valid=%b data=%h exp 0/0000", rsp_valid, rsp_data); end
        nChecks++; if (count !== 3'd0 || err_ovf !== 1'b0 || err_unf !== 1'b0) begin nFails++; $display("[TB] FAIL reset_state: count=%0d ovf=%b unf=%b exp 0/0/0", count, err_ovf, err_unf); end
    endtask

    // Three back-to-back pushes write addresses 0,1,2 on consecutive cycles.
    task automatic test_push();
        logic [WIDTH-1:0] vals [3];
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, OP_PUSH, vals[i], 1'b0);
            nChecks++; if (mem_we !== 1'b1 || mem_a !== AW'(i) || mem_din !== vals[i]) begin nFails++; $display("[TB] FAIL push%0d: we=%b a=%0d din=%h exp 1/%0d/%h", i, mem_we, mem_a, mem_din, i, vals[i]); end
        end
        applyStimulus(1'b0, OP_NOP, '0, 1'b0);
        nChecks++; if (mem_we !== 1'b0 || count !== 3'd3) begin nFails++; $display("[TB] FAIL push_count: we=%b count=%0d exp 0/3", mem_we, count); end
    endtask

    // One POP/TOP with rsp_ready high: response two cycles after acceptance.
    task automatic test_read(input logic [1:0] op, input logic [WIDTH-1:0] expData,
                             input logic [AW:0] expCount);
        applyStimulus(1'b1, op, '0, 1'b0);
        nChecks++; if (req_ready !== 1'b1) begin nFails++; $display("[TB] FAIL rd_accept: ready=%b exp 1", req_ready); end
        applyStimulus(1'b0, OP_NOP, '0, 1'b0);
        nChecks++; if (mem_we !== 1'b0 || rsp_valid !== 1'b0 || count !== expCount) begin nFails++; $display("[TB] FAIL rd_cycle: we=%b valid=%b count=%0d exp 0/0/%0d", mem_we, rsp_valid, count, expCount); end
        applyStimulus(1'b0, OP_NOP, '0, 1'b0);
        nChecks++; if (rsp_valid !== 1'b1 || rsp_data !== expData) begin nFails++; $display("[TB] FAIL rd_rsp: valid=%b data=%h exp 1/%h", rsp_valid, rsp_data, expData); end
        applyStimulus(1'b0, OP_NOP, '0, 1'b0);
        nChecks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin nFails++; $display("[TB] FAIL rd_done: valid=%b ready=%b exp 0/1", rsp_valid, req_ready); end
    endtask

    // Fill to NWORDS, overflow, clear, then clear racing a new overflow.
    task automatic test_overflow();
        applyStimulus(1'b1, OP_PUSH, 16'h4444, 1'b0);
        applyStimulus(1'b1, OP_PUSH, 16'h5555, 1'b0);
        applyStimulus(1'b1, OP_PUSH, 16'hBEEF, 1'b0);
        nChecks++; if (mem_we !== 1'b0 || count !== 3'd4 || mem_a !== 2'd0) begin nFails++; $display("[TB] FAIL ovf_nowrite: we=%b count=%0d a=%0d exp 0/4/0", mem_we, count, mem_a); end
        applyStimulus(1'b0, OP_NOP, '0, 1'b0);
        nChecks++; if (err_ovf !== 1'b1 || count !== 3'd4) begin nFails++; $display("[TB] FAIL ovf_flag: ovf=%b count=%0d exp 1/4", err_ovf, count); end
        applyStimulus(1'b0, OP_NOP, '0, 1'b1);
        applyStimulus(1'b0, OP_NOP, '0, 1'b0);
        nChecks++; if (err_ovf !== 1'b0) begin nFails++; $display("[TB] FAIL ovf_clear: ovf=%b exp 0", err_ovf); end
        applyStimulus(1'b1, OP_PUSH, 16'hBEEF, 1'b1);
        applyStimulus(1'b0, OP_NOP, '0, 1'b0);
        nChecks++; if (err_ovf !== 1'b1 || count !== 3'd4) begin nFails++; $display("[TB] FAIL ovf_clr_race: ovf=%b count=%0d exp 1/4", err_ovf, count); end
    endtask

    // Consumer stalls for 5 cycles: response held, no new request accepted.
    task automatic test_rsp_hold();
        rsp_ready = 1'b0;
        applyStimulus(1'b1, OP_POP, '0, 1'b0);
        applyStimulus(1'b1, OP_PUSH, 16'hDEAD, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, OP_PUSH, 16'hDEAD, 1'b0);
            nChecks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h5555 || req_ready !== 1'b0 || mem_we !== 1'b0) begin nFails++; $display("[TB] FAIL hold%0d: valid=%b data=%h ready=%b we=%b exp 1/5555/0/0", i, rsp_valid, rsp_data, req_ready, mem_we); end
        end
        applyStimulus(1'b0, OP_NOP, '0, 1'b0);
        rsp_ready = 1'b1;
        applyStimulus(1'b0, OP_NOP, '0, 1'b0);
        nChecks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || count !== 3'd3) begin nFails++; $display("[TB] FAIL hold_release: valid=%b ready=%b count=%0d exp 0/1/3", rsp_valid, req_ready, count); end
    endtask

    // Drain remaining words in LIFO order, then POP on an empty stack.
    task automatic test_underflow();
        test_read(OP_POP, 16'h4444, 3'd2);
        test_read(OP_POP, 16'h2222, 3'd1);
        test_read(OP_POP, 16'h1111, 3'd0);
        applyStimulus(1'b1, OP_POP, '0, 1'b0);
        applyStimulus(1'b0, OP_NOP, '0, 1'b0);
        nChecks++; if (err_unf !== 1'b1 || count !== 3'd0 || req_ready !== 1'b1) begin nFails++; $display("[TB] FAIL unf_flag: unf=%b count=%0d ready=%b exp 1/0/1", err_unf, count, req_ready); end
        applyStimulus(1'b0, OP_NOP, '0, 1'b0);
        nChecks++; if (rsp_valid !== 1'b0) begin nFails++; $display("[TB] FAIL unf_norsp: valid=%b exp 0", rsp_valid); end
    endtask

    // Reset while the controller sits in RD discards the pending response.
    task automatic test_reset_in_rd();
        applyStimulus(1'b1, OP_PUSH, 16'h7777, 1'b0);
        applyStimulus(1'b1, OP_POP, '0, 1'b0);
        applyStimulus(1'b0, OP_NOP, '0, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b0, OP_NOP, '0, 1'b0);
        reset = 1'b0;
        #1;
`ifdef STACK_CTRL_SCRUB_EN
        nChecks++; if (busy !== 1'b1 || mem_a !== 2'd0) begin nFails++; $display("[TB] FAIL rst_rd_scrub: busy=%b a=%0d exp 1/0", busy, mem_a); end
        for (int i = 0; i < NWORDS; i++) applyStimulus(1'b0, OP_NOP, '0, 1'b0);
`endif
        nChecks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || count !== 3'd0) begin nFails++; $display("[TB] FAIL rst_rd_state: ready=%b valid=%b count=%0d exp 1/0/0", req_ready, rsp_valid, count); end
        nChecks++; if (err_ovf !== 1'b0 || err_unf !== 1'b0 || rsp_data !== 16'h0) begin nFails++; $display("[TB] FAIL rst_rd_flags: ovf=%b unf=%b data=%h exp 0/0/0000", err_ovf, err_unf, rsp_data); end
    endtask

    initial begin
        test_reset();
        test_push();
        test_read(OP_POP, 16'h3333, 3'd2);
        test_read(OP_TOP, 16'h2222, 3'd2);
        test_overflow();
        test_rsp_hold();
        test_underflow();
        test_reset_in_rd();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
